// File: rtl/bcd_display_scan_pkg.sv
// Shared types and segment constants for the multiplexed BCD display scanner.
// Segment bit order is gfedcba, active-high.
package bcd_display_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIG0 = 2'd1,
      DIG1 = 2'd2,
      DIG2 = 2'd3
   } scan_state_t;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   function automatic logic [2:0] anode_of(input scan_state_t s);
      logic [2:0] a;
      a = 3'b000;
      case (s)
         DIG0:    a = 3'b001;
         DIG1:    a = 3'b010;
         DIG2:    a = 3'b100;
         default: a = 3'b000;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder (gfedcba, active-high).
// Non-BCD codes render as a dash so corrupt digits are visible on the panel.
module bcd_to_seg7
   import bcd_display_scan_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 3-digit 7-segment scanner with frame-coherent digit snapshot.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros in the hundreds/tens slots.
//
// state | meaning
// IDLE  | display blanked, waiting for the first prescaler tick
// DIG0  | units slot driven (An bit0); entered with a fresh snapshot
// DIG1  | tens slot driven (An bit1)
// DIG2  | hundreds slot driven (An bit2); next tick wraps and re-captures
module bcd_display_scan
   import bcd_display_scan_pkg::*;
#(
   parameter int SCAN_DIV   = 1000,
   parameter bit ACTIVE_LOW = 1'b0
)(
   input  logic       Clock,
   input  logic       nReset,
   input  logic       Enable,
   input  logic [3:0] Di1,
   input  logic [3:0] Di10,
   input  logic [3:0] Di100,
   output logic [6:0] Seg,
   output logic [2:0] An,
   output logic       FrameStart
);

   localparam int            PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
   localparam logic [6:0]    SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0]    AN_POL  = ACTIVE_LOW ? 3'h7 : 3'h0;

   logic [PW-1:0] prescaler;
   logic          tick;
   scan_state_t   state, state_nxt;
   logic [3:0]    snap_1, snap_10, snap_100;
   logic          capture;
   logic [3:0]    src_1, src_10, src_100;
   logic [3:0]    dig_sel;
   logic [6:0]    seg_dec;
   logic          blank;
   logic [6:0]    seg_nxt;
   logic [2:0]    an_nxt;
   logic          fs_nxt;

   assign tick = Enable && (prescaler == PS_LAST);

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         prescaler <= '0;
      end else if (!Enable || tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!Enable) begin
         state_nxt = IDLE;
      end else if (tick) begin
         case (state)
            IDLE:    state_nxt = DIG0;
            DIG0:    state_nxt = DIG1;
            DIG1:    state_nxt = DIG2;
            DIG2:    state_nxt = DIG0;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Capture happens on every edge that lands in DIG0, so a frame is never torn.
   assign capture = tick && ((state == IDLE) || (state == DIG2));

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         snap_1   <= 4'd0;
         snap_10  <= 4'd0;
         snap_100 <= 4'd0;
      end else if (capture) begin
         snap_1   <= Di1;
         snap_10  <= Di10;
         snap_100 <= Di100;
      end
   end

   // On capture edges the register is not loaded yet, so decode straight from the inputs.
   assign src_1   = capture ? Di1   : snap_1;
   assign src_10  = capture ? Di10  : snap_10;
   assign src_100 = capture ? Di100 : snap_100;

   always_comb begin
      dig_sel = src_1;
      case (state_nxt)
         DIG1:    dig_sel = src_10;
         DIG2:    dig_sel = src_100;
         default: dig_sel = src_1;
      endcase
   end

   bcd_to_seg7 u_dec (
      .digit (dig_sel),
      .seg   (seg_dec)
   );

`ifdef LEADING_ZERO_BLANK_EN
   assign blank = ((state_nxt == DIG2) && (src_100 == 4'd0)) ||
                  ((state_nxt == DIG1) && (src_100 == 4'd0) && (src_10 == 4'd0));
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      an_nxt  = anode_of(state_nxt);
      seg_nxt = seg_dec;
      if ((state_nxt == IDLE) || blank) begin
         seg_nxt = SEG_OFF;
      end
      fs_nxt = tick && (state == DIG2);
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         Seg        <= SEG_OFF ^ SEG_POL;
         An         <= 3'b000 ^ AN_POL;
         FrameStart <= 1'b0;
      end else begin
         Seg        <= seg_nxt ^ SEG_POL;
         An         <= an_nxt ^ AN_POL;
         FrameStart <= fs_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan (SCAN_DIV=4, ACTIVE_LOW=0).
// Directed scenarios, a table of frame vectors and randomized traffic against a reference model.
module tb_bcd_display_scan;

   localparam int SCAN_DIV = 4;
   localparam bit AL       = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] BZ = 7'h00;
   localparam bit         LZB = 1'b1;
`else
   localparam logic [6:0] BZ = 7'h3F;
   localparam bit         LZB = 1'b0;
`endif
   localparam logic [6:0] SP = AL ? 7'h7F : 7'h00;
   localparam logic [2:0] AP = AL ? 3'h7 : 3'h0;

   logic       Clock, nReset, Enable;
   logic [3:0] Di1, Di10, Di100;
   logic [6:0] Seg;
   logic [2:0] An;
   logic       FrameStart;

   int checks   = 0;
   int failures = 0;

   bcd_display_scan #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(AL)) dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .Enable     (Enable),
      .Di1        (Di1),
      .Di10       (Di10),
      .Di100      (Di100),
      .Seg        (Seg),
      .An         (An),
      .FrameStart (FrameStart)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic [6:0] dec_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: counts enabled edges; every SCAN_DIV-th one advances a slot 0,1,2,0,...
   int         en_cnt = 0;
   logic [3:0] snap [0:2] = '{4'd0, 4'd0, 4'd0};
   logic [6:0] m_seg = 7'h00;
   logic [2:0] m_an  = 3'b000;
   logic       m_fs  = 1'b0;
   bit         model_on = 1'b1;

   function automatic logic [6:0] ref_seg(input int slot);
      if (LZB && slot == 2 && snap[2] == 4'd0) return 7'h00;
      if (LZB && slot == 1 && snap[2] == 4'd0 && snap[1] == 4'd0) return 7'h00;
      return dec_tab[snap[slot]];
   endfunction

   always @(posedge Clock or negedge nReset) begin
      int k, slot;
      if (!nReset) begin
         en_cnt = 0;
         snap[0] = 4'd0; snap[1] = 4'd0; snap[2] = 4'd0;
         m_seg = 7'h00; m_an = 3'b000; m_fs = 1'b0;
      end else begin
         m_fs = 1'b0;
         if (!Enable) begin
            en_cnt = 0;
            m_seg = 7'h00;
            m_an  = 3'b000;
         end else begin
            en_cnt++;
            if (en_cnt % SCAN_DIV == 0) begin
               k    = en_cnt / SCAN_DIV;
               slot = (k - 1) % 3;
               if (slot == 0) begin
                  snap[0] = Di1; snap[1] = Di10; snap[2] = Di100;
                  m_fs = (k > 1);
               end
               m_an  = 3'b001 << slot;
               m_seg = ref_seg(slot);
            end
         end
      end
   end

   always @(negedge Clock) begin
      if (model_on) begin
         check("model_seg", Seg, m_seg ^ SP);
         check("model_an", An, m_an ^ AP);
         check("model_fs", FrameStart, m_fs);
      end
   end

   task automatic wait_an(input logic [2:0] v);
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock);
         if (An === (v ^ AP)) return;
      end
      check("wait_an_timeout", An, v ^ AP);
   endtask

   task automatic wait_frame();
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock);
         if (FrameStart === 1'b1) return;
      end
      check("wait_frame_timeout", FrameStart, 1'b1);
   endtask

   typedef struct {
      logic [3:0] d100, d10, d1;
      logic [6:0] eu, et, eh;
   } vec_t;
   vec_t vecs [0:5];

   initial begin
      vecs[0] = '{4'd1, 4'd2, 4'd3, 7'h4F, 7'h5B, 7'h06};
      vecs[1] = '{4'd4, 4'd5, 4'd6, 7'h7D, 7'h6D, 7'h66};
      vecs[2] = '{4'd9, 4'd8, 4'd7, 7'h07, 7'h7F, 7'h6F};
      vecs[3] = '{4'd0, 4'hC, 4'd0, 7'h3F, 7'h40, BZ};
      vecs[4] = '{4'd0, 4'd0, 4'd5, 7'h6D, BZ, BZ};
      vecs[5] = '{4'hF, 4'd0, 4'hA, 7'h40, 7'h3F, 7'h40};

      nReset = 1'b0; Enable = 1'b1;
      Di100 = 4'd1; Di10 = 4'd2; Di1 = 4'd3;
      #12;
      check("reset_seg", Seg, 7'h00 ^ SP);
      check("reset_an", An, 3'b000 ^ AP);
      check("reset_fs", FrameStart, 1'b0);

      // Normal scan from reset release
      @(negedge Clock);
      nReset = 1'b1;
      for (int e = 1; e <= 17; e++) begin
         @(negedge Clock);
         if (e == 3)  check("scan_e3_an", An, 3'b000 ^ AP);
         if (e == 4)  begin check("scan_e4_an", An, 3'b001 ^ AP); check("scan_e4_seg", Seg, 7'h4F ^ SP); check("scan_e4_fs", FrameStart, 1'b0); end
         if (e == 8)  begin check("scan_e8_an", An, 3'b010 ^ AP); check("scan_e8_seg", Seg, 7'h5B ^ SP); end
         if (e == 12) begin check("scan_e12_an", An, 3'b100 ^ AP); check("scan_e12_seg", Seg, 7'h06 ^ SP); end
         if (e == 16) begin check("scan_e16_an", An, 3'b001 ^ AP); check("scan_e16_seg", Seg, 7'h4F ^ SP); check("scan_e16_fs", FrameStart, 1'b1); end
         if (e == 17) check("scan_e17_fs", FrameStart, 1'b0);
      end

      // Mid-frame input change must not leak into the current frame
      wait_an(3'b010);
      Di1 = 4'd7; Di100 = 4'd9;
      wait_an(3'b100);
      check("snap_hund_held", Seg, 7'h06 ^ SP);
      wait_frame();
      check("snap_units_new_an", An, 3'b001 ^ AP);
      check("snap_units_new", Seg, 7'h07 ^ SP);

      // Enable drop and re-enable
      wait_an(3'b010);
      Enable = 1'b0;
      @(negedge Clock);
      check("dis_an", An, 3'b000 ^ AP);
      check("dis_seg", Seg, 7'h00 ^ SP);
      check("dis_fs", FrameStart, 1'b0);
      Enable = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(negedge Clock);
         check("reen_wait_an", An, 3'b000 ^ AP);
      end
      @(negedge Clock);
      check("reen_an", An, 3'b001 ^ AP);
      check("reen_seg", Seg, 7'h07 ^ SP);

      // Asynchronous reset between edges
      wait_an(3'b100);
      @(posedge Clock);
      #3 nReset = 1'b0;
      #1;
      check("arst_seg", Seg, 7'h00 ^ SP);
      check("arst_an", An, 3'b000 ^ AP);
      check("arst_fs", FrameStart, 1'b0);
      #2 nReset = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge Clock);
         check("arst_restart_an", An, ((e == 4) ? 3'b001 : 3'b000) ^ AP);
      end

      // Table of frames
      wait_an(3'b100);
      for (int v = 0; v < 6; v++) begin
         Di100 = vecs[v].d100; Di10 = vecs[v].d10; Di1 = vecs[v].d1;
         wait_frame();
         check("vec_units_an", An, 3'b001 ^ AP);
         check("vec_units_seg", Seg, vecs[v].eu ^ SP);
         repeat (SCAN_DIV) @(negedge Clock);
         check("vec_tens_an", An, 3'b010 ^ AP);
         check("vec_tens_seg", Seg, vecs[v].et ^ SP);
         repeat (SCAN_DIV) @(negedge Clock);
         check("vec_hund_an", An, 3'b100 ^ AP);
         check("vec_hund_seg", Seg, vecs[v].eh ^ SP);
      end

      // Randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         @(negedge Clock);
         if ($urandom_range(0, 7) == 0) begin
            Di1   = 4'($urandom_range(0, 15));
            Di10  = 4'($urandom_range(0, 15));
            Di100 = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 4) == 0) begin
            Di1 = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 0) begin Di100 = 4'd0; Di10 = 4'($urandom_range(0, 1)); end
         end
         Enable = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      end

      @(negedge Clock);
      model_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
